// File: rtl/amba_axi_pkg.sv
`default_nettype none
// ============================================================================
// Package     : amba_axi_pkg
// Description : AXI4 bus widths, burst/response encodings and the bundled
//               master-to-slave / slave-to-master channel structs.
// Revision    : 1.0 - initial release
// ============================================================================
package amba_axi_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  // Burst type encodings
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  // Response encodings
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Request channels driven by the master
  typedef struct packed {
    logic [AXI_ID_W-1:0]   awid;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  bready;
    logic [AXI_ID_W-1:0]   arid;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  rready;
  } s_axi_mosi_t;

  // Response channels driven by the slave
  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic                  buser;
    logic                  bvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  ruser;
    logic                  rvalid;
  } s_axi_miso_t;

endpackage : amba_axi_pkg
`default_nettype wire

// File: rtl/jtag_axi_pkg.sv
`default_nettype none
// ============================================================================
// Package     : jtag_axi_pkg
// Description : State encodings for the AXI memory slave write and read FSMs.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_axi_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } axi_mem_fsm_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } axi_rd_fsm_t;

endpackage : jtag_axi_pkg
`default_nettype wire

// File: rtl/axi_slave_mem_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : axi_slave_mem_addr_gen
// Description : Per-beat address helper: word index into the array, legality
//               of the beat (inside the window, FIXED/INCR only) and the
//               address of the following beat.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_slave_mem_addr_gen
  import amba_axi_pkg::*;
#(
  parameter int                    MEM_WORDS = 256,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                    IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic [AXI_ADDR_W-1:0] addr,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [AXI_ADDR_W-1:0] next_addr,
  output logic [IDX_W-1:0]      word_idx,
  output logic                  beat_ok
);

  logic [AXI_ADDR_W-1:0] w_offset;
  logic                  w_in_window;
  logic                  w_burst_ok;
  logic                  unused_offset_lsbs;

  // Modulo-2^width subtraction: addresses below the base wrap to huge offsets
  // and therefore fail the window test below.
  assign w_offset    = addr - BASE_ADDR;
  assign w_in_window = (w_offset[AXI_ADDR_W-1:IDX_W+2] == '0);
  assign w_burst_ok  = (burst == AXI_BURST_FIXED) || (burst == AXI_BURST_INCR);
  assign beat_ok     = w_in_window && w_burst_ok;
  assign word_idx    = w_offset[IDX_W+1:2];

  // FIXED holds the address; everything else advances by the beat size.
  assign next_addr = (burst == AXI_BURST_FIXED) ? addr
                                                : addr + (AXI_ADDR_W'(1) << size);

  assign unused_offset_lsbs = ^w_offset[1:0];

endmodule : axi_slave_mem_addr_gen
`default_nettype wire

// File: rtl/axi_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : axi_slave_mem
// Description : AXI4 slave backed by a flop array. Independent write and read
//               FSMs; reads sample the array before same-cycle writes land.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_slave_mem
  import amba_axi_pkg::*;
  import jtag_axi_pkg::*;
#(
  parameter int                    MEM_WORDS  = 256,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [AXI_DATA_W-1:0] RESET_DATA = '0
) (
  input  logic        clk,
  input  logic        aresn,
  input  s_axi_mosi_t axi_mosi_i,
  output s_axi_miso_t axi_miso_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int BYTES = AXI_DATA_W / 8;

  logic [AXI_DATA_W-1:0] r_mem [MEM_WORDS];
  logic                  r_live;

  // Write side
  axi_mem_fsm_t          r_wr_state, w_wr_next;
  logic [AXI_ID_W-1:0]   r_wr_id;
  logic [AXI_ADDR_W-1:0] r_wr_addr;
  logic [7:0]            r_wr_len, r_wr_cnt;
  logic [2:0]            r_wr_size;
  logic [1:0]            r_wr_burst;
  logic                  r_wr_err;
  logic                  w_awready, w_wready, w_bvalid;
  logic                  w_aw_hs, w_w_hs;
  logic [AXI_ADDR_W-1:0] w_wr_next_addr;
  logic [IDX_W-1:0]      w_wr_idx;
  logic                  w_wr_ok;

  // Read side
  axi_rd_fsm_t           r_rd_state, w_rd_next;
  logic [AXI_ID_W-1:0]   r_rd_id;
  logic [AXI_ADDR_W-1:0] r_rd_addr;
  logic [7:0]            r_rd_len, r_rd_cnt;
  logic [2:0]            r_rd_size;
  logic [1:0]            r_rd_burst;
  logic [AXI_DATA_W-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rlast;
  logic                  w_arready, w_rvalid;
  logic                  w_ar_hs, w_r_hs, w_rd_fetch;
  logic [AXI_ADDR_W-1:0] w_rd_cur_addr, w_rd_next_addr;
  logic [2:0]            w_rd_cur_size;
  logic [1:0]            w_rd_cur_burst;
  logic [IDX_W-1:0]      w_rd_idx;
  logic                  w_rd_ok;

  // Ready flags stay low until the first clock after reset release.
  always_ff @(posedge clk or negedge aresn) begin
    if (!aresn) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // ---------------------------------------------------------------- write FSM
  // Write state register
  always_ff @(posedge clk or negedge aresn) begin
    if (!aresn) r_wr_state <= W_IDLE;
    else        r_wr_state <= w_wr_next;
  end

  // Write next-state and channel handshake outputs
  always_comb begin
    w_wr_next = r_wr_state;
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_bvalid  = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        w_awready = r_live;
        if (r_live && axi_mosi_i.awvalid) w_wr_next = W_DATA;
      end
      W_DATA: begin
        w_wready = 1'b1;
        if (axi_mosi_i.wvalid && axi_mosi_i.wlast) w_wr_next = W_RESP;
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (axi_mosi_i.bready) w_wr_next = W_IDLE;
      end
      default: w_wr_next = W_IDLE;
    endcase
  end

  assign w_aw_hs = w_awready && axi_mosi_i.awvalid;
  assign w_w_hs  = w_wready && axi_mosi_i.wvalid;

  axi_slave_mem_addr_gen #(
    .MEM_WORDS (MEM_WORDS),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) u_wr_addr_gen (
    .addr      (r_wr_addr),
    .size      (r_wr_size),
    .burst     (r_wr_burst),
    .next_addr (w_wr_next_addr),
    .word_idx  (w_wr_idx),
    .beat_ok   (w_wr_ok)
  );

  // Write burst context; the error flag is sticky for the whole burst and
  // also catches wlast arriving early (on wlast) or late (beat awlen+1 without it).
  always_ff @(posedge clk or negedge aresn) begin
    if (!aresn) begin
      r_wr_id    <= '0;
      r_wr_addr  <= '0;
      r_wr_len   <= '0;
      r_wr_cnt   <= '0;
      r_wr_size  <= '0;
      r_wr_burst <= '0;
      r_wr_err   <= 1'b0;
    end else if (w_aw_hs) begin
      r_wr_id    <= axi_mosi_i.awid;
      r_wr_addr  <= axi_mosi_i.awaddr;
      r_wr_len   <= axi_mosi_i.awlen;
      r_wr_cnt   <= '0;
      r_wr_size  <= axi_mosi_i.awsize;
      r_wr_burst <= axi_mosi_i.awburst;
      r_wr_err   <= 1'b0;
    end else if (w_w_hs) begin
      r_wr_addr <= w_wr_next_addr;
      r_wr_cnt  <= r_wr_cnt + 8'd1;
      r_wr_err  <= r_wr_err | ~w_wr_ok |
                   (axi_mosi_i.wlast ? (r_wr_cnt != r_wr_len) : (r_wr_cnt == r_wr_len));
    end
  end

  // Storage array with byte-lane write enables
  always_ff @(posedge clk or negedge aresn) begin
    if (!aresn) begin
      for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= RESET_DATA;
    end else if (w_w_hs && w_wr_ok) begin
      for (int b = 0; b < BYTES; b++) begin
        if (axi_mosi_i.wstrb[b]) r_mem[w_wr_idx][8*b +: 8] <= axi_mosi_i.wdata[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read FSM
  // Read state register
  always_ff @(posedge clk or negedge aresn) begin
    if (!aresn) r_rd_state <= R_IDLE;
    else        r_rd_state <= w_rd_next;
  end

  // Read next-state and channel handshake outputs
  always_comb begin
    w_rd_next = r_rd_state;
    w_arready = 1'b0;
    w_rvalid  = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        w_arready = r_live;
        if (r_live && axi_mosi_i.arvalid) w_rd_next = R_DATA;
      end
      R_DATA: begin
        w_rvalid = 1'b1;
        if (axi_mosi_i.rready && r_rlast) w_rd_next = R_IDLE;
      end
      default: w_rd_next = R_IDLE;
    endcase
  end

  assign w_ar_hs    = w_arready && axi_mosi_i.arvalid;
  assign w_r_hs     = w_rvalid && axi_mosi_i.rready;
  assign w_rd_fetch = w_ar_hs || (w_r_hs && !r_rlast);

  // The first beat is fetched straight off the AR channel; later beats use
  // the stored next-beat address.
  assign w_rd_cur_addr  = (r_rd_state == R_IDLE) ? axi_mosi_i.araddr  : r_rd_addr;
  assign w_rd_cur_size  = (r_rd_state == R_IDLE) ? axi_mosi_i.arsize  : r_rd_size;
  assign w_rd_cur_burst = (r_rd_state == R_IDLE) ? axi_mosi_i.arburst : r_rd_burst;

  axi_slave_mem_addr_gen #(
    .MEM_WORDS (MEM_WORDS),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) u_rd_addr_gen (
    .addr      (w_rd_cur_addr),
    .size      (w_rd_cur_size),
    .burst     (w_rd_cur_burst),
    .next_addr (w_rd_next_addr),
    .word_idx  (w_rd_idx),
    .beat_ok   (w_rd_ok)
  );

  // Read burst context and registered R payload (held while stalled)
  always_ff @(posedge clk or negedge aresn) begin
    if (!aresn) begin
      r_rd_id    <= '0;
      r_rd_addr  <= '0;
      r_rd_len   <= '0;
      r_rd_cnt   <= '0;
      r_rd_size  <= '0;
      r_rd_burst <= '0;
      r_rdata    <= '0;
      r_rresp    <= AXI_RESP_OKAY;
      r_rlast    <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_rd_id    <= axi_mosi_i.arid;
        r_rd_len   <= axi_mosi_i.arlen;
        r_rd_cnt   <= '0;
        r_rd_size  <= axi_mosi_i.arsize;
        r_rd_burst <= axi_mosi_i.arburst;
        r_rlast    <= (axi_mosi_i.arlen == 8'd0);
      end else if (w_r_hs) begin
        if (r_rlast) begin
          r_rlast <= 1'b0;
        end else begin
          r_rd_cnt <= r_rd_cnt + 8'd1;
          r_rlast  <= ((r_rd_cnt + 8'd1) == r_rd_len);
        end
      end
      if (w_rd_fetch) begin
        r_rd_addr <= w_rd_next_addr;
        r_rdata   <= w_rd_ok ? r_mem[w_rd_idx] : '0;
        r_rresp   <= w_rd_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end
    end
  end

  // ------------------------------------------------------------------ outputs
  // Assemble the slave response bundle
  always_comb begin
    axi_miso_o         = '0;
    axi_miso_o.awready = w_awready;
    axi_miso_o.wready  = w_wready;
    axi_miso_o.bvalid  = w_bvalid;
    axi_miso_o.bid     = r_wr_id;
    axi_miso_o.bresp   = r_wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    axi_miso_o.buser   = 1'b0;
    axi_miso_o.arready = w_arready;
    axi_miso_o.rvalid  = w_rvalid;
    axi_miso_o.rid     = r_rd_id;
    axi_miso_o.rdata   = r_rdata;
    axi_miso_o.rresp   = r_rresp;
    axi_miso_o.rlast   = r_rlast;
    axi_miso_o.ruser   = 1'b0;
  end

endmodule : axi_slave_mem
`default_nettype wire

// File: tb/tb_axi_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_slave_mem
// Description : Self-checking bench for axi_slave_mem: directed scenarios plus
//               randomized bursts compared against a word-array reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_slave_mem;
  import amba_axi_pkg::*;

  localparam int          WORDS = 256;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] RDATA = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        aresn;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;

  int tests = 0;
  int fails = 0;

  logic [31:0] mm [WORDS];       // reference memory
  logic [31:0] wq [0:15];        // write beat data
  logic [3:0]  sq [0:15];        // write beat strobes

  always #5 clk = ~clk;

  axi_slave_mem #(
    .MEM_WORDS  (WORDS),
    .BASE_ADDR  (BASE),
    .RESET_DATA (RDATA)
  ) dut (
    .clk        (clk),
    .aresn      (aresn),
    .axi_mosi_i (mosi),
    .axi_miso_o (miso)
  );

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference rules, written from the address map
  function automatic bit beat_ok(input logic [31:0] a, input logic [1:0] bu);
    logic [31:0] off;
    off = a - BASE;
    return (bu == AXI_BURST_FIXED || bu == AXI_BURST_INCR) && (off < WORDS * 4);
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off >> 2);
  endfunction

  function automatic logic [31:0] next_a(input logic [31:0] a, input logic [2:0] sz,
                                         input logic [1:0] bu);
    return (bu == AXI_BURST_INCR) ? a + (32'd1 << sz) : a;
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0:       return miso.awready;
      1:       return miso.wready;
      2:       return miso.bvalid;
      3:       return miso.arready;
      default: return miso.rvalid;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input string tag);
    int k;
    k = 0;
    while (sig(sel) !== 1'b1 && k < 64) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_wait"}, sig(sel), 1);
  endtask

  task automatic model_reset();
    for (int i = 0; i < WORDS; i++) mm[i] = RDATA;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, miso.awready, 0);
    check({tag, "_arready"}, miso.arready, 0);
    check({tag, "_wready"},  miso.wready,  0);
    check({tag, "_bvalid"},  miso.bvalid,  0);
    check({tag, "_rvalid"},  miso.rvalid,  0);
    check({tag, "_rlast"},   miso.rlast,   0);
    check({tag, "_bresp"},   miso.bresp,   AXI_RESP_OKAY);
    check({tag, "_rresp"},   miso.rresp,   AXI_RESP_OKAY);
    check({tag, "_rdata"},   miso.rdata,   0);
    check({tag, "_ids"},     {miso.bid, miso.rid}, 0);
    check({tag, "_user"},    {miso.buser, miso.ruser}, 0);
  endtask

  // Full write burst: nb beats from wq/sq, wlast on the final one
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bu, input int nb,
                           input string tag);
    logic [31:0] a;
    logic        err;
    a   = addr;
    err = (nb != int'(len) + 1);
    for (int i = 0; i < nb; i++) begin
      if (beat_ok(a, bu)) begin
        for (int b = 0; b < 4; b++) if (sq[i][b]) mm[widx(a)][8*b +: 8] = wq[i][8*b +: 8];
      end else begin
        err = 1'b1;
      end
      a = next_a(a, sz, bu);
    end
    mosi.awid = id; mosi.awaddr = addr; mosi.awlen = len;
    mosi.awsize = sz; mosi.awburst = bu; mosi.awvalid = 1'b1;
    wait_sig(0, {tag, "_aw"});
    @(posedge clk); #1;
    mosi.awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      mosi.wvalid = 1'b1; mosi.wdata = wq[i]; mosi.wstrb = sq[i];
      mosi.wlast  = (i == nb - 1);
      wait_sig(1, {tag, "_w"});
      @(posedge clk); #1;
    end
    mosi.wvalid = 1'b0; mosi.wlast = 1'b0;
    mosi.bready = 1'b1;
    wait_sig(2, {tag, "_b"});
    check({tag, "_bresp"}, miso.bresp, err ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
    check({tag, "_bid"}, miso.bid, id);
    @(posedge clk); #1;
    mosi.bready = 1'b0;
    check({tag, "_bdone"}, miso.bvalid, 0);
  endtask

  // Full read burst; toggle=1 stalls with rready on every other cycle
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu, input bit toggle,
                          input string tag);
    logic [31:0] exp_d [256];
    logic [1:0]  exp_r [256];
    logic [31:0] a;
    int          n, cyc;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      exp_d[i] = beat_ok(a, bu) ? mm[widx(a)] : 32'd0;
      exp_r[i] = beat_ok(a, bu) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      a = next_a(a, sz, bu);
    end
    mosi.arid = id; mosi.araddr = addr; mosi.arlen = len;
    mosi.arsize = sz; mosi.arburst = bu; mosi.arvalid = 1'b1;
    wait_sig(3, {tag, "_ar"});
    @(posedge clk); #1;
    mosi.arvalid = 1'b0;
    check({tag, "_latency"}, miso.rvalid, 1);
    n = 0; cyc = 0;
    while (n <= int'(len) && cyc < 4 * int'(len) + 16) begin
      mosi.rready = toggle ? (cyc % 2 == 1) : 1'b1;
      check({tag, "_rvalid"}, miso.rvalid, 1);
      check({tag, "_rdata"},  miso.rdata,  exp_d[n]);
      check({tag, "_rresp"},  miso.rresp,  exp_r[n]);
      check({tag, "_rid"},    miso.rid,    id);
      check({tag, "_rlast"},  miso.rlast,  (n == int'(len)));
      @(posedge clk); #1;
      if (mosi.rready) n++;
      cyc++;
    end
    mosi.rready = 1'b0;
    check({tag, "_beats"}, n, int'(len) + 1);
    check({tag, "_rdone"}, miso.rvalid, 0);
  endtask

  initial begin
    logic [31:0] addr, old;
    logic [2:0]  sz;
    logic [7:0]  ln;
    logic [1:0]  bu;
    int          kind, nb;

    mosi  = '0;
    aresn = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    aresn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("live_awready", miso.awready, 1);
    check("live_arready", miso.arready, 1);

    // Single word write then read back
    wq[0] = 32'hDEAD_BEEF; sq[0] = 4'hF;
    axi_write(4'd0, BASE + 32'h10, 8'd0, 3'd2, AXI_BURST_INCR, 1, "single_w");
    axi_read (4'd0, BASE + 32'h10, 8'd0, 3'd2, AXI_BURST_INCR, 1'b0, "single_r");

    // INCR burst of four, id 5
    for (int i = 0; i < 4; i++) begin wq[i] = 32'(i + 1); sq[i] = 4'hF; end
    axi_write(4'd5, BASE + 32'h20, 8'd3, 3'd2, AXI_BURST_INCR, 4, "incr_w");
    axi_read (4'd5, BASE + 32'h20, 8'd3, 3'd2, AXI_BURST_INCR, 1'b0, "incr_r");

    // Partial strobe over all-ones
    wq[0] = 32'hFFFF_FFFF; sq[0] = 4'hF;
    axi_write(4'd1, BASE, 8'd0, 3'd2, AXI_BURST_INCR, 1, "ones_w");
    wq[0] = 32'h1122_3344; sq[0] = 4'h3;
    axi_write(4'd1, BASE, 8'd0, 3'd2, AXI_BURST_INCR, 1, "strb_w");
    axi_read (4'd1, BASE, 8'd0, 3'd2, AXI_BURST_INCR, 1'b0, "strb_r");

    // Just past the array, below the base, WRAP bursts
    wq[0] = 32'h0BAD_0BAD; sq[0] = 4'hF;
    axi_write(4'd2, BASE + WORDS * 4, 8'd0, 3'd2, AXI_BURST_INCR, 1, "oor_w");
    axi_read (4'd2, BASE + WORDS * 4, 8'd0, 3'd2, AXI_BURST_INCR, 1'b0, "oor_r");
    axi_write(4'd2, BASE - 32'd4, 8'd0, 3'd2, AXI_BURST_INCR, 1, "below_w");
    for (int i = 0; i < 4; i++) begin wq[i] = $urandom; sq[i] = 4'hF; end
    axi_write(4'd3, BASE + 32'h40, 8'd3, 3'd2, AXI_BURST_WRAP, 4, "wrap_w");
    axi_read (4'd3, BASE + 32'h40, 8'd3, 3'd2, AXI_BURST_WRAP, 1'b0, "wrap_r");
    // Burst straddling the top of the array
    axi_write(4'd4, BASE + WORDS * 4 - 8, 8'd3, 3'd2, AXI_BURST_INCR, 4, "cross_w");
    axi_read (4'd4, BASE + WORDS * 4 - 8, 8'd3, 3'd2, AXI_BURST_INCR, 1'b0, "cross_r");
    // FIXED burst keeps hitting one word
    axi_write(4'd6, BASE + 32'h80, 8'd3, 3'd2, AXI_BURST_FIXED, 4, "fixed_w");
    axi_read (4'd6, BASE + 32'h80, 8'd1, 3'd2, AXI_BURST_INCR, 1'b0, "fixed_r");
    // wlast early and late
    axi_write(4'd7, BASE + 32'hC0, 8'd3, 3'd2, AXI_BURST_INCR, 2, "short_w");
    axi_write(4'd7, BASE + 32'hD0, 8'd1, 3'd2, AXI_BURST_INCR, 3, "long_w");
    axi_read (4'd7, BASE + 32'hC0, 8'd7, 3'd2, AXI_BURST_INCR, 1'b0, "len_r");

    // Eight beats read with rready toggling
    for (int i = 0; i < 8; i++) begin wq[i] = $urandom; sq[i] = 4'hF; end
    axi_write(4'd8, BASE + 32'h100, 8'd7, 3'd2, AXI_BURST_INCR, 8, "stall_w");
    axi_read (4'd8, BASE + 32'h100, 8'd7, 3'd2, AXI_BURST_INCR, 1'b1, "stall_r");

    // Read and write of the same word in the same cycle returns the old value
    old = mm[widx(BASE + 32'h10)];
    mosi.awid = 4'd1; mosi.awaddr = BASE + 32'h10; mosi.awlen = 8'd0;
    mosi.awsize = 3'd2; mosi.awburst = AXI_BURST_INCR; mosi.awvalid = 1'b1;
    wait_sig(0, "col_aw");
    @(posedge clk); #1;
    mosi.awvalid = 1'b0;
    mosi.wvalid = 1'b1; mosi.wdata = 32'hCAFE_F00D; mosi.wstrb = 4'hF; mosi.wlast = 1'b1;
    mosi.arid = 4'd3; mosi.araddr = BASE + 32'h10; mosi.arlen = 8'd0;
    mosi.arsize = 3'd2; mosi.arburst = AXI_BURST_INCR; mosi.arvalid = 1'b1;
    check("col_wready", miso.wready, 1);
    check("col_arready", miso.arready, 1);
    @(posedge clk); #1;
    mosi.wvalid = 1'b0; mosi.wlast = 1'b0; mosi.arvalid = 1'b0;
    mm[widx(BASE + 32'h10)] = 32'hCAFE_F00D;
    check("col_rvalid", miso.rvalid, 1);
    check("col_rdata", miso.rdata, old);
    check("col_bvalid", miso.bvalid, 1);
    mosi.rready = 1'b1; mosi.bready = 1'b1;
    @(posedge clk); #1;
    mosi.rready = 1'b0; mosi.bready = 1'b0;
    axi_read(4'd3, BASE + 32'h10, 8'd0, 3'd2, AXI_BURST_INCR, 1'b0, "col_after");

    // Randomized bursts against the reference memory
    for (int t = 0; t < 40; t++) begin
      sz   = 3'($urandom_range(0, 2));
      ln   = 8'($urandom_range(0, 7));
      kind = $urandom_range(0, 9);
      bu   = (kind == 0) ? AXI_BURST_WRAP : ((kind < 3) ? AXI_BURST_FIXED : AXI_BURST_INCR);
      kind = $urandom_range(0, 9);
      if (kind == 0)      addr = BASE + WORDS * 4 + ($urandom & 32'hFC);
      else if (kind == 1) addr = BASE - 32'd32;
      else                addr = BASE + 32'($urandom_range(0, WORDS * 4 - 1));
      addr = addr & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 1) == 1) begin
        nb = ($urandom_range(0, 7) == 0) ? int'(ln) : int'(ln) + 1;
        if (nb == 0) nb = 2;
        for (int i = 0; i < nb; i++) begin wq[i] = $urandom; sq[i] = 4'($urandom); end
        axi_write(4'($urandom), addr, ln, sz, bu, nb, "rnd_w");
      end else begin
        axi_read(4'($urandom), addr, ln, sz, bu, 1'($urandom), "rnd_r");
      end
    end
    axi_read(4'd9, BASE, 8'd255, 3'd2, AXI_BURST_INCR, 1'b0, "dump1");

    // Reset pulsed during beat 2 of a four-beat write
    mosi.awid = 4'd2; mosi.awaddr = BASE + 32'h200; mosi.awlen = 8'd3;
    mosi.awsize = 3'd2; mosi.awburst = AXI_BURST_INCR; mosi.awvalid = 1'b1;
    wait_sig(0, "mid_aw");
    @(posedge clk); #1;
    mosi.awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mosi.wvalid = 1'b1; mosi.wdata = $urandom; mosi.wstrb = 4'hF; mosi.wlast = 1'b0;
      wait_sig(1, "mid_w");
      @(posedge clk); #1;
    end
    mosi.wdata = $urandom;
    #2;
    aresn = 1'b0;
    #1;
    check_reset_outputs("mid_rst_async");
    mosi.wvalid = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("mid_rst_held");
    aresn = 1'b1;
    model_reset();
    mosi.bready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("mid_no_bvalid", miso.bvalid, 0);
    end
    mosi.bready = 1'b0;
    check("mid_awready", miso.awready, 1);
    axi_read(4'd10, BASE, 8'd255, 3'd2, AXI_BURST_INCR, 1'b0, "dump2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_axi_slave_mem
`default_nettype wire
